fir_serializer: RTL

- Parallel-to-serial stage directly upstream of the FIR front-end deserializer.
- Accepts LENGTH-bit sample words over a valid/ready handshake and emits them one bit per enabled clock, LSB first.
- Emits a last-bit strobe on the MSB bit, which drives the deserializer's input-valid.
- Word buffer plus shift register allows zero-gap back-to-back words.

---
 rtl/fir_serializer.sv | 116 +++++++++++
 1 files changed

// File: rtl/fir_serializer.sv
// Parallel-to-serial stage feeding the FIR front-end deserializer: LSB-first, one bit per enabled clock.
// Optional inter-word idle gap enabled by defining FIR_SERIALIZER_GAP_EN.
module fir_serializer #(
  parameter int unsigned LENGTH     = 24,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [LENGTH-1:0] iv_din,
  input  logic              i_din_valid,
  output logic              o_din_ready,
  output logic              o_dout,
  output logic              o_dout_last,
  output logic              o_busy
);

  localparam int unsigned CNT_W = (LENGTH > 2) ? $clog2(LENGTH) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Reject parameter values the datapath cannot represent.
  if (LENGTH < 2) begin : g_bad_length
    $error("fir_serializer: LENGTH must be >= 2");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("fir_serializer: GAP_CYCLES must be >= 1");
  end

  state_t              state;
  logic                hold_full;
  logic [LENGTH-1:0]   hold;
  logic [LENGTH-1:0]   shift;
  logic [CNT_W-1:0]    cnt;
`ifdef FIR_SERIALIZER_GAP_EN
  logic [GAP_W-1:0]    gcnt;
`endif

  assign o_din_ready = !hold_full && !i_rst;
  assign o_busy      = (state != IDLE) || hold_full;

  // Accept and load are mutually exclusive: accept needs an empty buffer, load a full one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      hold_full   <= 1'b0;
      hold        <= '0;
      shift       <= '0;
      cnt         <= '0;
      o_dout      <= 1'b0;
      o_dout_last <= 1'b0;
`ifdef FIR_SERIALIZER_GAP_EN
      gcnt        <= '0;
`endif
    end else begin
      if (i_din_valid && o_din_ready) begin
        hold      <= iv_din;
        hold_full <= 1'b1;
      end
      if (i_en) begin
        case (state)
          IDLE: begin
            o_dout_last <= 1'b0;
            if (hold_full) begin
              o_dout    <= hold[0];
              shift     <= hold >> 1;
              cnt       <= CNT_W'(1);
              hold_full <= 1'b0;
              state     <= SHIFT;
            end else begin
              o_dout <= 1'b0;
            end
          end
          SHIFT: begin
            o_dout <= shift[0];
            shift  <= shift >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(LENGTH - 1)) begin
              o_dout_last <= 1'b1;
`ifdef FIR_SERIALIZER_GAP_EN
              gcnt  <= '0;
              state <= GAP;
`else
              state <= IDLE;
`endif
            end else begin
              o_dout_last <= 1'b0;
            end
          end
`ifdef FIR_SERIALIZER_GAP_EN
          GAP: begin
            o_dout      <= 1'b0;
            o_dout_last <= 1'b0;
            if (gcnt == GAP_W'(GAP_CYCLES - 1)) begin
              state <= IDLE;
            end else begin
              gcnt <= gcnt + GAP_W'(1);
            end
          end
`endif
          default: begin
            o_dout      <= 1'b0;
            o_dout_last <= 1'b0;
            state       <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
